hex_display_driver: RTL and testbench

Consumer side of the six-digit HEX interface: accepts six 4-bit digit codes (d0..d5) from a producer such as the blink/counter blocks, double-buffers them so each update is tear-free, decodes each to an active-low 7-segment pattern, and applies global PWM dimming. Its outputs drive the board HEX0..HEX5 pins directly. Code 4'hF is the producer's "digit off" code and is blanked when BLANK_EN=1.

---
 rtl/hex_display_driver.sv | 144 ++++++++++++++
 tb/tb_hex_display_driver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_driver.sv
// Six-digit HEX display consumer: double-buffers incoming digit codes, commits
// them at PWM frame boundaries, decodes to active-low 7-segment and dims by PWM.
module hex_display_driver #(
  parameter bit          BLANK_EN = 1'b1,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                ms_clk,
  input  logic                Reset_n,
  input  logic [3:0]          d0,
  input  logic [3:0]          d1,
  input  logic [3:0]          d2,
  input  logic [3:0]          d3,
  input  logic [3:0]          d4,
  input  logic [3:0]          d5,
  input  logic                load,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [6:0]          HEX0,
  output logic [6:0]          HEX1,
  output logic [6:0]          HEX2,
  output logic [6:0]          HEX3,
  output logic [6:0]          HEX4,
  output logic [6:0]          HEX5,
  output logic                pending
);

  localparam int unsigned DIGITS = 6;
  localparam int unsigned DW     = 4;
  localparam int unsigned SW     = 7;

  localparam logic [DW-1:0]       CODE_OFF = 4'hF;
  localparam logic [SW-1:0]       SEG_DARK = 7'h7F;
  localparam logic [PWM_BITS-1:0] PWM_LAST = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DW-1:0]       din    [DIGITS];
  logic [DW-1:0]       shadow [DIGITS];
  logic [DW-1:0]       active [DIGITS];
  logic [SW-1:0]       hex_q  [DIGITS];
  logic [SW-1:0]       hex_c  [DIGITS];
  logic                commit_c;
  logic                on_c;

  assign din[0] = d0;
  assign din[1] = d1;
  assign din[2] = d2;
  assign din[3] = d3;
  assign din[4] = d4;
  assign din[5] = d5;

  // Frame boundary and PWM duty, both from the pre-increment counter
  assign commit_c = (pwm_cnt == PWM_LAST);
  assign on_c     = (pwm_cnt <= brightness);

  function automatic logic [SW-1:0] seg(input logic [DW-1:0] code);
    logic [SW-1:0] s;
    case (code)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge ms_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Shadow/active double buffer; a load on the commit edge bypasses to active
  always_ff @(posedge ms_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pending <= 1'b0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
        shadow[k] <= CODE_OFF;
        active[k] <= CODE_OFF;
      end
    end else begin
      if (load) begin
        for (int unsigned k = 0; k < DIGITS; k++) begin
          shadow[k] <= din[k];
        end
      end
      if (commit_c) begin
        pending <= 1'b0;
        if (load) begin
          for (int unsigned k = 0; k < DIGITS; k++) begin
            active[k] <= din[k];
          end
        end else if (pending) begin
          for (int unsigned k = 0; k < DIGITS; k++) begin
            active[k] <= shadow[k];
          end
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < DIGITS; k++) begin
      hex_c[k] = SEG_DARK;
      if (on_c && !(BLANK_EN && (active[k] == CODE_OFF))) begin
        hex_c[k] = seg(active[k]);
      end
    end
  end

  always_ff @(posedge ms_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        hex_q[k] <= SEG_DARK;
      end
    end else begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        hex_q[k] <= hex_c[k];
      end
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed bench for hex_display_driver: one blanking instance and one non-blanking
// instance share all inputs; expected segments come from a reference font table.
module tb_hex_display_driver;

  typedef logic [3:0] codes_t [6];

  logic       ms_clk = 1'b0;
  logic       Reset_n;
  codes_t     d;
  logic       load;
  logic [3:0] brightness;
  logic [6:0] hb [6];
  logic [6:0] hn [6];
  logic       pend_b;
  logic       pend_n;

  logic [3:0] cnt;
  int         total = 0;
  int         bad   = 0;

  always #5 ms_clk = ~ms_clk;

  hex_display_driver #(.BLANK_EN(1'b1), .PWM_BITS(4)) dut_b (
    .ms_clk(ms_clk), .Reset_n(Reset_n),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]), .d4(d[4]), .d5(d[5]),
    .load(load), .brightness(brightness),
    .HEX0(hb[0]), .HEX1(hb[1]), .HEX2(hb[2]), .HEX3(hb[3]), .HEX4(hb[4]), .HEX5(hb[5]),
    .pending(pend_b)
  );

  hex_display_driver #(.BLANK_EN(1'b0), .PWM_BITS(4)) dut_n (
    .ms_clk(ms_clk), .Reset_n(Reset_n),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]), .d4(d[4]), .d5(d[5]),
    .load(load), .brightness(brightness),
    .HEX0(hn[0]), .HEX1(hn[1]), .HEX2(hn[2]), .HEX3(hn[3]), .HEX4(hn[4]), .HEX5(hn[5]),
    .pending(pend_n)
  );

  function automatic logic [6:0] ref_seg(input logic [3:0] c);
    case (c)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic codes_t all_of(input logic [3:0] v);
    codes_t c;
    for (int k = 0; k < 6; k++) c[k] = v;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Both instances against the displayed codes; lit=0 expects every digit dark
  task automatic chk_disp(input string tag, input codes_t c, input bit lit);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("%s blank HEX%0d", tag, k), 32'(hb[k]),
          32'((lit && c[k] != 4'hF) ? ref_seg(c[k]) : 7'h7F));
      chk($sformatf("%s noblank HEX%0d", tag, k), 32'(hn[k]),
          32'(lit ? ref_seg(c[k]) : 7'h7F));
    end
  endtask

  task automatic chk_pend(input string tag, input logic exp);
    chk({tag, " pending_b"}, 32'(pend_b), 32'(exp));
    chk({tag, " pending_n"}, 32'(pend_n), 32'(exp));
  endtask

  // cnt tracks the DUT pwm_cnt value in force before the next rising edge
  task automatic step();
    @(posedge ms_clk);
    @(negedge ms_clk);
    cnt = cnt + 4'd1;
  endtask

  task automatic go_to(input logic [3:0] target);
    while (cnt != target) step();
  endtask

  task automatic pwm_run(input logic [3:0] b, input int exp_lit);
    int lit_n;
    int dark_n;
    brightness = b;
    step();
    lit_n  = 0;
    dark_n = 0;
    repeat (64) begin
      step();
      if (hb[0] == 7'h12 && hb[5] == 7'h12 && hn[3] == 7'h12) lit_n++;
      else if (hb[0] == 7'h7F && hb[5] == 7'h7F && hn[3] == 7'h7F) dark_n++;
    end
    chk($sformatf("pwm b=%0d lit", b), 32'(lit_n), 32'(exp_lit));
    chk($sformatf("pwm b=%0d dark", b), 32'(dark_n), 32'(64 - exp_lit));
  endtask

  initial begin
    codes_t cur;
    codes_t nw;
    logic [3:0] pre;
    int phase;

    Reset_n    = 1'b0;
    load       = 1'b0;
    brightness = 4'hF;
    d          = all_of(4'h0);
    cnt        = 4'd0;
    repeat (3) @(negedge ms_clk);
    chk_disp("reset", all_of(4'hF), 1'b0);
    chk_pend("reset", 1'b0);
    Reset_n = 1'b1;

    // No load after reset: blanked instance stays dark, other shows "F"
    repeat (40) begin
      step();
      chk_disp("idle", all_of(4'hF), 1'b1);
    end

    // Basic decode
    go_to(4'd3);
    d[0] = 4'h0; d[1] = 4'h1; d[2] = 4'h8; d[3] = 4'hA; d[4] = 4'hE; d[5] = 4'hF;
    cur  = d;
    load = 1'b1;
    step();
    load = 1'b0;
    chk_pend("load", 1'b1);
    go_to(4'd0);
    chk_disp("commit edge old", all_of(4'hF), 1'b1);
    chk_pend("commit", 1'b0);
    step();
    chk_disp("decode", cur, 1'b1);

    // Tear-free: two loads within one frame, only the last one shows
    go_to(4'd2);
    d    = all_of(4'h1);
    load = 1'b1;
    step();
    load = 1'b0;
    while (cnt != 4'd9) begin
      chk_disp("tear first", cur, 1'b1);
      step();
    end
    d    = all_of(4'h2);
    load = 1'b1;
    step();
    load = 1'b0;
    while (cnt != 4'd1) begin
      chk_disp("tear second", cur, 1'b1);
      step();
    end
    cur = all_of(4'h2);
    chk_disp("tear final", cur, 1'b1);
    chk_pend("tear final", 1'b0);

    // Load exactly on the commit edge with pending shadow data
    go_to(4'd5);
    d    = all_of(4'h3);
    load = 1'b1;
    step();
    load = 1'b0;
    chk_pend("collide pre", 1'b1);
    go_to(4'd15);
    d    = all_of(4'h5);
    load = 1'b1;
    step();
    load = 1'b0;
    d    = all_of(4'h9);
    chk_pend("collide", 1'b0);
    chk_disp("collide edge", cur, 1'b1);
    step();
    cur = all_of(4'h5);
    chk_disp("collide bypass", cur, 1'b1);
    repeat (20) begin
      step();
      chk_disp("collide hold", cur, 1'b1);
    end

    // Brightness threshold: lit for pwm_cnt 7, dark for 8
    brightness = 4'd7;
    step();
    go_to(4'd8);
    chk_disp("bright 7 at 7", cur, 1'b1);
    step();
    chk_disp("bright 7 at 8", cur, 1'b0);

    pwm_run(4'd0, 4);
    pwm_run(4'd7, 32);
    pwm_run(4'd15, 64);

    // Producer blink: changes land only on frame boundaries
    brightness = 4'hF;
    for (int blk = 0; blk < 4; blk++) begin
      nw   = (blk % 2 == 0) ? all_of(4'h0) : all_of(4'hF);
      d    = nw;
      load = 1'b1;
      pre  = cnt;
      step();
      load  = 1'b0;
      d     = all_of(4'h7);
      phase = (pre == 4'd15) ? 1 : 0;
      repeat (99) begin
        chk_disp($sformatf("blink%0d", blk), (phase == 2) ? nw : cur, 1'b1);
        pre = cnt;
        step();
        if (phase == 0 && pre == 4'd15) phase = 1;
        else if (phase == 1 && pre == 4'd0) phase = 2;
      end
      chk_disp($sformatf("blink%0d end", blk), nw, 1'b1);
      cur = nw;
    end

    // Async reset mid-frame with pending data: shadow is discarded
    go_to(4'd6);
    d    = all_of(4'h8);
    load = 1'b1;
    step();
    load = 1'b0;
    chk_pend("prereset", 1'b1);
    step();
    #2;
    Reset_n = 1'b0;
    #1;
    chk_disp("async reset", all_of(4'hF), 1'b0);
    chk_pend("async reset", 1'b0);
    @(negedge ms_clk);
    Reset_n = 1'b1;
    cnt     = 4'd0;
    repeat (40) begin
      step();
      chk_disp("post reset", all_of(4'hF), 1'b1);
    end
    chk_pend("post reset", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
